decode_stage_param: RTL and testbench
=====================================

DECODE_STAGE_PARAM -- requirements
Module: decode_stage_param

Interface
REQ-001 Parameter DATA_WIDTH, default 32, datapath/PC width; legal values >=32.
REQ-002 Parameter REG_ADDR_W, default 5, register index width; register file holds 2**REG_ADDR_W entries.
REQ-003 Parameter BRANCH_IN_ID, default 1, 1 = BEQ/BNE resolved in this stage, 0 = branch type forwarded to EX.
REQ-004 i_clk  in  1  sole clock, all state updates on rising edge.
REQ-005 i_reset_n  in  1  asynchronous, active-low reset.
REQ-006 i_instruction  in  32  instruction from IF; i_pc  in  DATA_WIDTH  PC+4 of that instruction; i_valid  in  1  instruction present.
REQ-007 i_wb_we  in  1, i_wb_addr  in  REG_ADDR_W, i_wb_data  in  DATA_WIDTH  write-back port.
REQ-008 i_ex_mem_read  in  1, i_ex_rt  in  REG_ADDR_W  load in EX and its destination, for load-use detection.
REQ-009 i_flush  in  1  squash current instruction; i_halt  in  1  freeze stage and register file writes.
REQ-010 i_dbg_addr  in  REG_ADDR_W, o_dbg_data  out  DATA_WIDTH  independent combinational debug read port.
REQ-011 o_valid  out  1; o_ra, o_rb, o_imm  out  DATA_WIDTH; o_rs, o_rt, o_rd  out  REG_ADDR_W; o_opcode, o_funct  out  6; o_shamt  out  5; all registered ID/EX fields.
REQ-012 o_ctl_wb  out  2 {mem_to_reg, reg_write}; o_ctl_mem  out  5 {read, write, unsigned, width[1:0]}; o_ctl_ex  out  4 {reg_dest, alu_op[1:0], alu_src}; o_br_type  out  2 (00 none, 01 BEQ, 10 BNE); all registered.
REQ-013 o_stall_req  out  1, o_jump  out  1, o_jump_addr  out  DATA_WIDTH  combinational; o_program_end  out  1  registered, sticky.

Function
REQ-014 Latency one cycle: fields decoded from i_instruction appear on ID/EX outputs after the next rising edge.
REQ-015 Update priority per edge: reset > halt (hold all registers) > flush or load-use or !i_valid or program_end (bubble) > normal decode.
REQ-016 Bubble: o_valid=0, o_ctl_wb/o_ctl_mem/o_ctl_ex/o_br_type=0; data fields don't-care but deterministic (zero).
REQ-017 Instruction 0x00000000 decodes as bubble.
REQ-018 Load-use: o_stall_req=1 when i_valid && i_ex_mem_read && i_ex_rt!=0 && (i_ex_rt==rs || i_ex_rt==rt); inserts bubble, forces o_jump=0.
REQ-019 Control: R-type {wb=11, mem=0, ex: reg_dest=1, alu_op=10, alu_src=0}; JR same but reg_write=0; JALR alu_op=00; loads (op[5:3]=100) wb=01, mem read=1, unsigned=op[2], width=op[1:0], ex=0_00_1; stores (101) wb=10, mem write=1, ex=0_00_1; immediates (001) wb=11, ex=0_11_1; JAL wb=11, ex=1_00_0; branches/J wb=10, ex=0_01_1.
REQ-020 o_imm = sign-extended instr[15:0] to DATA_WIDTH.
REQ-021 JAL: o_ra=i_pc, o_rb=4, o_rt=0, o_rd=all-ones; JALR: o_ra=i_pc, o_rb=4, o_rt=0, o_rd=instr[15:11]; else o_ra/o_rb = register reads, o_rd=instr[15:11].
REQ-022 Register file: reset clears all entries; write when i_wb_we && !i_halt && i_wb_addr!=0; entry 0 reads zero always.
REQ-023 Write-through bypass: read of address equal to i_wb_addr while write enabled (addr!=0, !i_halt) returns i_wb_data same cycle, on both operand ports and o_dbg_data.
REQ-024 J/JAL: o_jump=1, o_jump_addr={i_pc[DATA_WIDTH-1:28], instr[25:0], 00}; JR/JALR: o_jump=1, address=bypassed rs value.
REQ-025 BRANCH_IN_ID=1: BEQ/BNE compare bypassed rs/rt; taken -> o_jump=1, address=i_pc+(o_imm<<2) modulo 2**DATA_WIDTH; o_br_type=00. BRANCH_IN_ID=0: branches never assert o_jump, o_br_type registered per REQ-012.
REQ-026 o_jump=0 whenever !i_valid, i_flush, i_halt, o_stall_req or o_program_end.
REQ-027 Valid 0xFFFFFFFF accepted (not halted/flushed/stalled) sets o_program_end on that edge; it and bubble mode persist until reset.

Reset
REQ-028 Asynchronous assertion of i_reset_n=0 immediately clears all registered outputs, o_program_end and every register file entry; mid-operation state is discarded.
REQ-029 Deassertion synchronous-safe: first decode on first rising edge with i_reset_n=1.

Verification
REQ-030 WB writes r5=0x12345678 while ADD r3,r5,r0 decoded same cycle -> o_ra=0x12345678 next edge (bypass).
REQ-031 i_ex_mem_read=1, i_ex_rt=7, instruction ADD r1,r7,r2 -> o_stall_req=1, next edge o_valid=0, all ctl=0.
REQ-032 BEQ r1,r1,-2 at i_pc=0x100, BRANCH_IN_ID=1 -> o_jump=1, o_jump_addr=0xF8; BRANCH_IN_ID=0 -> o_jump=0, o_br_type=01 next edge.
REQ-033 JAL target 0x40 at i_pc=0x20 -> o_jump_addr=0x100; next edge o_ra=0x20, o_rb=4, o_rd=31.
REQ-034 i_halt=1 with i_wb_we=1 -> outputs held, register unchanged via o_dbg_data.
REQ-035 0xFFFFFFFF accepted -> o_program_end=1; later ADD yields bubbles; i_reset_n pulse low clears all.

Source files
------------

// File: rtl/decode_stage_param.sv
// Instruction decode stage: register file with write-through bypass, control
// decode, load-use stall detection, jump/branch resolution and ID/EX register.
module decode_stage_param #(
    parameter int DATA_WIDTH   = 32,
    parameter int REG_ADDR_W   = 5,
    parameter bit BRANCH_IN_ID = 1'b1
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic [31:0]           i_instruction,
    input  logic [DATA_WIDTH-1:0] i_pc,
    input  logic                  i_valid,
    input  logic                  i_wb_we,
    input  logic [REG_ADDR_W-1:0] i_wb_addr,
    input  logic [DATA_WIDTH-1:0] i_wb_data,
    input  logic                  i_ex_mem_read,
    input  logic [REG_ADDR_W-1:0] i_ex_rt,
    input  logic                  i_flush,
    input  logic                  i_halt,
    input  logic [REG_ADDR_W-1:0] i_dbg_addr,
    output logic [DATA_WIDTH-1:0] o_dbg_data,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_ra,
    output logic [DATA_WIDTH-1:0] o_rb,
    output logic [DATA_WIDTH-1:0] o_imm,
    output logic [REG_ADDR_W-1:0] o_rs,
    output logic [REG_ADDR_W-1:0] o_rt,
    output logic [REG_ADDR_W-1:0] o_rd,
    output logic [5:0]            o_opcode,
    output logic [5:0]            o_funct,
    output logic [4:0]            o_shamt,
    output logic [1:0]            o_ctl_wb,
    output logic [4:0]            o_ctl_mem,
    output logic [3:0]            o_ctl_ex,
    output logic [1:0]            o_br_type,
    output logic                  o_stall_req,
    output logic                  o_jump,
    output logic [DATA_WIDTH-1:0] o_jump_addr,
    output logic                  o_program_end
);

    localparam int NUM_REGS = 2 ** REG_ADDR_W;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_JALR  = 6'h09;

    typedef struct packed {
        logic                  valid;
        logic [DATA_WIDTH-1:0] ra;
        logic [DATA_WIDTH-1:0] rb;
        logic [DATA_WIDTH-1:0] imm;
        logic [REG_ADDR_W-1:0] rs;
        logic [REG_ADDR_W-1:0] rt;
        logic [REG_ADDR_W-1:0] rd;
        logic [5:0]            opcode;
        logic [5:0]            funct;
        logic [4:0]            shamt;
        logic [1:0]            ctl_wb;
        logic [4:0]            ctl_mem;
        logic [3:0]            ctl_ex;
        logic [1:0]            br_type;
    } idex_t;

    logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
    idex_t                 r_idex;
    logic                  r_program_end;

    idex_t                 w_next;
    logic [5:0]            w_opcode;
    logic [5:0]            w_funct;
    logic [REG_ADDR_W-1:0] w_rs;
    logic [REG_ADDR_W-1:0] w_rt;
    logic [REG_ADDR_W-1:0] w_rd;
    logic [DATA_WIDTH-1:0] w_imm;
    logic [DATA_WIDTH-1:0] w_rs_val;
    logic [DATA_WIDTH-1:0] w_rt_val;
    logic                  w_wb_en;
    logic                  w_is_rtype, w_is_jr, w_is_jalr, w_is_j, w_is_jal;
    logic                  w_is_beq, w_is_bne, w_is_load, w_is_store, w_is_imm;
    logic                  w_is_end, w_stall, w_bubble, w_jump_raw, w_end_set;
    logic [1:0]            w_ctl_wb;
    logic [4:0]            w_ctl_mem;
    logic [3:0]            w_ctl_ex;
    logic [1:0]            w_br_type;
    logic [DATA_WIDTH-1:0] w_jump_addr;

    assign w_opcode = i_instruction[31:26];
    assign w_funct  = i_instruction[5:0];
    assign w_rs     = REG_ADDR_W'(i_instruction[25:21]);
    assign w_rt     = REG_ADDR_W'(i_instruction[20:16]);
    assign w_rd     = REG_ADDR_W'(i_instruction[15:11]);
    assign w_imm    = {{(DATA_WIDTH-16){i_instruction[15]}}, i_instruction[15:0]};

    assign w_is_rtype = (w_opcode == OP_RTYPE);
    assign w_is_jr    = w_is_rtype && (w_funct == FN_JR);
    assign w_is_jalr  = w_is_rtype && (w_funct == FN_JALR);
    assign w_is_j     = (w_opcode == OP_J);
    assign w_is_jal   = (w_opcode == OP_JAL);
    assign w_is_beq   = (w_opcode == OP_BEQ);
    assign w_is_bne   = (w_opcode == OP_BNE);
    assign w_is_load  = (w_opcode[5:3] == 3'b100);
    assign w_is_store = (w_opcode[5:3] == 3'b101);
    assign w_is_imm   = (w_opcode[5:3] == 3'b001);
    assign w_is_end   = (i_instruction == 32'hFFFF_FFFF);

    // A write being committed this cycle is visible to every read port at once.
    assign w_wb_en  = i_wb_we && !i_halt && (i_wb_addr != '0);
    assign w_rs_val = (w_rs == '0) ? '0 :
                      (w_wb_en && (w_rs == i_wb_addr)) ? i_wb_data : r_regs[w_rs];
    assign w_rt_val = (w_rt == '0) ? '0 :
                      (w_wb_en && (w_rt == i_wb_addr)) ? i_wb_data : r_regs[w_rt];
    assign o_dbg_data = (i_dbg_addr == '0) ? '0 :
                        (w_wb_en && (i_dbg_addr == i_wb_addr)) ? i_wb_data : r_regs[i_dbg_addr];

    assign w_stall = i_valid && i_ex_mem_read && (i_ex_rt != '0) &&
                     ((i_ex_rt == w_rs) || (i_ex_rt == w_rt));

    assign w_bubble = i_flush || w_stall || !i_valid || r_program_end ||
                      (i_instruction == 32'h0) || w_is_end;

    assign w_end_set = i_valid && w_is_end && !i_flush && !w_stall;

    // NOTE: always_comb outputs get a default first so no path infers a latch.
    always_comb begin
        w_ctl_wb  = '0;
        w_ctl_mem = '0;
        w_ctl_ex  = '0;
        w_br_type = '0;
        if (w_is_rtype) begin
            w_ctl_wb = w_is_jr ? 2'b10 : 2'b11;
            w_ctl_ex = w_is_jalr ? 4'b1000 : 4'b1100;
        end else if (w_is_load) begin
            w_ctl_wb  = 2'b01;
            w_ctl_mem = {1'b1, 1'b0, w_opcode[2], w_opcode[1:0]};
            w_ctl_ex  = 4'b0001;
        end else if (w_is_store) begin
            w_ctl_wb  = 2'b10;
            w_ctl_mem = {1'b0, 1'b1, 1'b0, w_opcode[1:0]};
            w_ctl_ex  = 4'b0001;
        end else if (w_is_imm) begin
            w_ctl_wb = 2'b11;
            w_ctl_ex = 4'b0111;
        end else if (w_is_jal) begin
            w_ctl_wb = 2'b11;
            w_ctl_ex = 4'b1000;
        end else if (w_is_j || w_is_beq || w_is_bne) begin
            w_ctl_wb = 2'b10;
            w_ctl_ex = 4'b0011;
            if (!BRANCH_IN_ID) begin
                w_br_type = w_is_beq ? 2'b01 : (w_is_bne ? 2'b10 : 2'b00);
            end
        end
    end

    always_comb begin
        w_jump_raw  = 1'b0;
        w_jump_addr = i_pc + (w_imm << 2);
        if (w_is_j || w_is_jal) begin
            w_jump_raw  = 1'b1;
            w_jump_addr = {i_pc[DATA_WIDTH-1:28], i_instruction[25:0], 2'b00};
        end else if (w_is_jr || w_is_jalr) begin
            w_jump_raw  = 1'b1;
            w_jump_addr = w_rs_val;
        end else if (BRANCH_IN_ID && (w_is_beq || w_is_bne)) begin
            w_jump_raw = w_is_beq ? (w_rs_val == w_rt_val) : (w_rs_val != w_rt_val);
        end
    end

    assign o_stall_req = w_stall;
    assign o_jump      = w_jump_raw && i_valid && !i_flush && !i_halt && !w_stall && !r_program_end;
    assign o_jump_addr = w_jump_addr;

    always_comb begin
        w_next = '0;
        if (!w_bubble) begin
            w_next.valid   = 1'b1;
            w_next.imm     = w_imm;
            w_next.rs      = w_rs;
            w_next.opcode  = w_opcode;
            w_next.funct   = w_funct;
            w_next.shamt   = i_instruction[10:6];
            w_next.ctl_wb  = w_ctl_wb;
            w_next.ctl_mem = w_ctl_mem;
            w_next.ctl_ex  = w_ctl_ex;
            w_next.br_type = w_br_type;
            w_next.rd      = w_rd;
            if (w_is_jal || w_is_jalr) begin
                w_next.ra = i_pc;
                w_next.rb = DATA_WIDTH'(4);
                w_next.rt = '0;
                if (w_is_jal) w_next.rd = '1;
            end else begin
                w_next.ra = w_rs_val;
                w_next.rb = w_rt_val;
                w_next.rt = w_rt;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_idex        <= '0;
            r_program_end <= 1'b0;
        end else if (!i_halt) begin
            r_idex <= w_next;
            if (w_end_set) r_program_end <= 1'b1;
        end
    end

    // NOTE: the register file is reset explicitly because software relies on
    // all entries reading zero after reset; this costs a reset on every flop.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
        end else if (w_wb_en) begin
            r_regs[i_wb_addr] <= i_wb_data;
        end
    end

    assign o_valid       = r_idex.valid;
    assign o_ra          = r_idex.ra;
    assign o_rb          = r_idex.rb;
    assign o_imm         = r_idex.imm;
    assign o_rs          = r_idex.rs;
    assign o_rt          = r_idex.rt;
    assign o_rd          = r_idex.rd;
    assign o_opcode      = r_idex.opcode;
    assign o_funct       = r_idex.funct;
    assign o_shamt       = r_idex.shamt;
    assign o_ctl_wb      = r_idex.ctl_wb;
    assign o_ctl_mem     = r_idex.ctl_mem;
    assign o_ctl_ex      = r_idex.ctl_ex;
    assign o_br_type     = r_idex.br_type;
    assign o_program_end = r_program_end;

endmodule

// File: tb/tb_decode_stage_param.sv
// Directed bench for decode_stage_param: one instance resolves branches in ID,
// a second forwards branch type to EX; both see identical stimulus.
module tb_decode_stage_param;

    logic        i_clk = 1'b0;
    logic        i_reset_n;
    logic [31:0] i_instruction, i_pc, i_wb_data;
    logic        i_valid, i_wb_we, i_ex_mem_read, i_flush, i_halt;
    logic [4:0]  i_wb_addr, i_ex_rt, i_dbg_addr;

    logic [31:0] a_dbg, a_ra, a_rb, a_imm, a_jaddr;
    logic [4:0]  a_rs, a_rt, a_rd, a_shamt, a_mem;
    logic [5:0]  a_op, a_fn;
    logic [1:0]  a_wb, a_br;
    logic [3:0]  a_ex;
    logic        a_valid, a_stall, a_jump, a_end;

    logic [31:0] b_dbg, b_ra, b_rb, b_imm, b_jaddr;
    logic [4:0]  b_rs, b_rt, b_rd, b_shamt, b_mem;
    logic [5:0]  b_op, b_fn;
    logic [1:0]  b_wb, b_br;
    logic [3:0]  b_ex;
    logic        b_valid, b_stall, b_jump, b_end;

    int checks = 0;
    int errors = 0;

    always #5 i_clk = ~i_clk;

    decode_stage_param #(.DATA_WIDTH(32), .REG_ADDR_W(5), .BRANCH_IN_ID(1'b1)) dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n), .i_instruction(i_instruction), .i_pc(i_pc),
        .i_valid(i_valid), .i_wb_we(i_wb_we), .i_wb_addr(i_wb_addr), .i_wb_data(i_wb_data),
        .i_ex_mem_read(i_ex_mem_read), .i_ex_rt(i_ex_rt), .i_flush(i_flush), .i_halt(i_halt),
        .i_dbg_addr(i_dbg_addr), .o_dbg_data(a_dbg), .o_valid(a_valid), .o_ra(a_ra),
        .o_rb(a_rb), .o_imm(a_imm), .o_rs(a_rs), .o_rt(a_rt), .o_rd(a_rd), .o_opcode(a_op),
        .o_funct(a_fn), .o_shamt(a_shamt), .o_ctl_wb(a_wb), .o_ctl_mem(a_mem), .o_ctl_ex(a_ex),
        .o_br_type(a_br), .o_stall_req(a_stall), .o_jump(a_jump), .o_jump_addr(a_jaddr),
        .o_program_end(a_end)
    );

    decode_stage_param #(.DATA_WIDTH(32), .REG_ADDR_W(5), .BRANCH_IN_ID(1'b0)) dut_ex (
        .i_clk(i_clk), .i_reset_n(i_reset_n), .i_instruction(i_instruction), .i_pc(i_pc),
        .i_valid(i_valid), .i_wb_we(i_wb_we), .i_wb_addr(i_wb_addr), .i_wb_data(i_wb_data),
        .i_ex_mem_read(i_ex_mem_read), .i_ex_rt(i_ex_rt), .i_flush(i_flush), .i_halt(i_halt),
        .i_dbg_addr(i_dbg_addr), .o_dbg_data(b_dbg), .o_valid(b_valid), .o_ra(b_ra),
        .o_rb(b_rb), .o_imm(b_imm), .o_rs(b_rs), .o_rt(b_rt), .o_rd(b_rd), .o_opcode(b_op),
        .o_funct(b_fn), .o_shamt(b_shamt), .o_ctl_wb(b_wb), .o_ctl_mem(b_mem), .o_ctl_ex(b_ex),
        .o_br_type(b_br), .o_stall_req(b_stall), .o_jump(b_jump), .o_jump_addr(b_jaddr),
        .o_program_end(b_end)
    );

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'd0, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle();
        i_valid = 1'b0; i_instruction = 32'h0; i_pc = 32'h0;
        i_wb_we = 1'b0; i_wb_addr = 5'd0; i_wb_data = 32'h0;
        i_ex_mem_read = 1'b0; i_ex_rt = 5'd0; i_flush = 1'b0; i_halt = 1'b0;
        i_dbg_addr = 5'd0;
    endtask

    task automatic issue(input logic [31:0] instr, input logic [31:0] pc);
        i_valid = 1'b1; i_instruction = instr; i_pc = pc;
    endtask

    task automatic test_reset();
        idle();
        i_reset_n = 1'b0;
        issue(rtype(5'd1, 5'd2, 5'd3, 6'h20), 32'h4);
        tick(); tick();
        checks++; if (a_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", a_valid); end
        checks++; if ({a_wb, a_mem, a_ex, a_br} !== 13'h0) begin errors++; $display("FAIL reset_ctl got %h exp 0", {a_wb, a_mem, a_ex, a_br}); end
        checks++; if (a_end !== 1'b0) begin errors++; $display("FAIL reset_end got %b exp 0", a_end); end
        i_reset_n = 1'b1;
        idle();
        tick();
    endtask

    task automatic test_bypass();
        i_wb_we = 1'b1; i_wb_addr = 5'd5; i_wb_data = 32'h1234_5678; i_dbg_addr = 5'd5;
        issue(rtype(5'd5, 5'd0, 5'd3, 6'h20), 32'h8);
        #1;
        checks++; if (a_dbg !== 32'h1234_5678) begin errors++; $display("FAIL bypass_dbg got %h exp 12345678", a_dbg); end
        tick();
        checks++; if (a_ra !== 32'h1234_5678) begin errors++; $display("FAIL bypass_ra got %h exp 12345678", a_ra); end
        checks++; if (a_rb !== 32'h0) begin errors++; $display("FAIL bypass_rb got %h exp 0", a_rb); end
        checks++; if ({a_valid, a_wb, a_ex} !== 7'b1_11_1100) begin errors++; $display("FAIL add_ctl got %b exp 1111100", {a_valid, a_wb, a_ex}); end
        checks++; if ({a_rs, a_rd, a_fn} !== {5'd5, 5'd3, 6'h20}) begin errors++; $display("FAIL add_fields got %h exp %h", {a_rs, a_rd, a_fn}, {5'd5, 5'd3, 6'h20}); end
        idle();
        i_dbg_addr = 5'd5;
        #1;
        checks++; if (a_dbg !== 32'h1234_5678) begin errors++; $display("FAIL regfile_r5 got %h exp 12345678", a_dbg); end
        tick();
    endtask

    task automatic test_load_use();
        i_ex_mem_read = 1'b1; i_ex_rt = 5'd7;
        issue(rtype(5'd7, 5'd2, 5'd1, 6'h20), 32'hC);
        #1;
        checks++; if (a_stall !== 1'b1) begin errors++; $display("FAIL loaduse_stall got %b exp 1", a_stall); end
        tick();
        checks++; if ({a_valid, a_wb, a_mem, a_ex, a_br} !== 14'h0) begin errors++; $display("FAIL loaduse_bubble got %h exp 0", {a_valid, a_wb, a_mem, a_ex, a_br}); end
        i_ex_rt = 5'd0;
        #1;
        checks++; if (a_stall !== 1'b0) begin errors++; $display("FAIL loaduse_r0 got %b exp 0", a_stall); end
        i_ex_rt = 5'd5;
        issue(rtype(5'd5, 5'd0, 5'd0, 6'h08), 32'h10);
        #1;
        checks++; if (a_jump !== 1'b0) begin errors++; $display("FAIL loaduse_jump got %b exp 0", a_jump); end
        idle();
        i_valid = 1'b1; i_instruction = 32'h0;
        tick();
        checks++; if (a_valid !== 1'b0) begin errors++; $display("FAIL zero_instr_valid got %b exp 0", a_valid); end
        idle();
    endtask

    task automatic test_branch();
        issue(itype(6'h04, 5'd1, 5'd1, 16'hFFFE), 32'h100);
        #1;
        checks++; if (a_jump !== 1'b1) begin errors++; $display("FAIL beq_jump got %b exp 1", a_jump); end
        checks++; if (a_jaddr !== 32'hF8) begin errors++; $display("FAIL beq_addr got %h exp 000000f8", a_jaddr); end
        checks++; if (b_jump !== 1'b0) begin errors++; $display("FAIL beq_ex_jump got %b exp 0", b_jump); end
        tick();
        checks++; if (a_br !== 2'b00) begin errors++; $display("FAIL beq_brtype_id got %b exp 00", a_br); end
        checks++; if (b_br !== 2'b01) begin errors++; $display("FAIL beq_brtype_ex got %b exp 01", b_br); end
        checks++; if ({a_wb, a_ex, a_imm} !== {2'b10, 4'b0011, 32'hFFFF_FFFE}) begin errors++; $display("FAIL beq_ctl got %h exp %h", {a_wb, a_ex, a_imm}, {2'b10, 4'b0011, 32'hFFFF_FFFE}); end
        issue(itype(6'h04, 5'd5, 5'd0, 16'h0010), 32'h200);
        #1;
        checks++; if (a_jump !== 1'b0) begin errors++; $display("FAIL beq_nt_jump got %b exp 0", a_jump); end
        issue(itype(6'h05, 5'd5, 5'd0, 16'h0010), 32'h200);
        #1;
        checks++; if ({a_jump, a_jaddr} !== {1'b1, 32'h240}) begin errors++; $display("FAIL bne_taken got %h exp 100000240", {a_jump, a_jaddr}); end
        tick();
        checks++; if (b_br !== 2'b10) begin errors++; $display("FAIL bne_brtype_ex got %b exp 10", b_br); end
        idle();
    endtask

    task automatic test_jump();
        issue({6'h03, 26'h40}, 32'h20);
        #1;
        checks++; if ({a_jump, a_jaddr} !== {1'b1, 32'h100}) begin errors++; $display("FAIL jal_addr got %h exp 100000100", {a_jump, a_jaddr}); end
        tick();
        checks++; if ({a_ra, a_rb} !== {32'h20, 32'h4}) begin errors++; $display("FAIL jal_ops got %h exp 0000002000000004", {a_ra, a_rb}); end
        checks++; if ({a_rd, a_rt, a_wb, a_ex} !== {5'd31, 5'd0, 2'b11, 4'b1000}) begin errors++; $display("FAIL jal_ctl got %h exp %h", {a_rd, a_rt, a_wb, a_ex}, {5'd31, 5'd0, 2'b11, 4'b1000}); end
        issue(rtype(5'd5, 5'd0, 5'd0, 6'h08), 32'h30);
        #1;
        checks++; if ({a_jump, a_jaddr} !== {1'b1, 32'h1234_5678}) begin errors++; $display("FAIL jr_addr got %h exp 112345678", {a_jump, a_jaddr}); end
        i_flush = 1'b1;
        #1;
        checks++; if (a_jump !== 1'b0) begin errors++; $display("FAIL jr_flush_jump got %b exp 0", a_jump); end
        i_flush = 1'b0;
        issue(rtype(5'd5, 5'd0, 5'd9, 6'h09), 32'h44);
        tick();
        checks++; if ({a_ra, a_rb, a_rd, a_rt, a_wb, a_ex} !== {32'h44, 32'h4, 5'd9, 5'd0, 2'b11, 4'b1000}) begin errors++; $display("FAIL jalr_fields got %h", {a_ra, a_rb, a_rd, a_rt, a_wb, a_ex}); end
        idle();
    endtask

    task automatic test_load_imm();
        issue(itype(6'h25, 5'd5, 5'd4, 16'h0008), 32'h50);
        tick();
        checks++; if ({a_wb, a_mem, a_ex} !== {2'b01, 5'b10101, 4'b0001}) begin errors++; $display("FAIL lhu_ctl got %b exp 01101010001", {a_wb, a_mem, a_ex}); end
        issue(itype(6'h08, 5'd5, 5'd4, 16'hFFFF), 32'h54);
        tick();
        checks++; if ({a_wb, a_mem, a_ex, a_imm} !== {2'b11, 5'b0, 4'b0111, 32'hFFFF_FFFF}) begin errors++; $display("FAIL addi_ctl got %h", {a_wb, a_mem, a_ex, a_imm}); end
        issue(itype(6'h23, 5'd5, 5'd4, 16'h0008), 32'h58);
        tick();
        checks++; if ({a_wb, a_mem, a_ex, a_imm, a_rt} !== {2'b01, 5'b10011, 4'b0001, 32'h8, 5'd4}) begin errors++; $display("FAIL lw_ctl got %h", {a_wb, a_mem, a_ex, a_imm, a_rt}); end
        idle();
    endtask

    task automatic test_halt();
        i_halt = 1'b1;
        i_wb_we = 1'b1; i_wb_addr = 5'd6; i_wb_data = 32'hDEAD_BEEF; i_dbg_addr = 5'd6;
        issue(itype(6'h08, 5'd1, 5'd2, 16'h0003), 32'h60);
        #1;
        checks++; if (a_dbg !== 32'h0) begin errors++; $display("FAIL halt_bypass got %h exp 0", a_dbg); end
        tick();
        checks++; if ({a_valid, a_mem, a_ex, a_imm} !== {1'b1, 5'b10011, 4'b0001, 32'h8}) begin errors++; $display("FAIL halt_hold got %h", {a_valid, a_mem, a_ex, a_imm}); end
        i_halt = 1'b0; i_wb_we = 1'b0;
        #1;
        checks++; if (a_dbg !== 32'h0) begin errors++; $display("FAIL halt_regfile got %h exp 0", a_dbg); end
        idle();
        tick();
    endtask

    task automatic test_program_end();
        issue(32'hFFFF_FFFF, 32'h70);
        tick();
        checks++; if ({a_end, a_valid} !== 2'b10) begin errors++; $display("FAIL end_set got %b exp 10", {a_end, a_valid}); end
        issue(rtype(5'd5, 5'd0, 5'd3, 6'h20), 32'h74);
        tick();
        checks++; if ({a_end, a_valid, a_wb} !== 4'b1000) begin errors++; $display("FAIL end_bubble got %b exp 1000", {a_end, a_valid, a_wb}); end
        issue({6'h02, 26'h10}, 32'h78);
        #1;
        checks++; if (a_jump !== 1'b0) begin errors++; $display("FAIL end_jump got %b exp 0", a_jump); end
        issue(rtype(5'd5, 5'd0, 5'd3, 6'h20), 32'h7C);
        #2;
        i_reset_n = 1'b0;
        i_dbg_addr = 5'd5;
        #1;
        checks++; if ({a_end, a_valid, a_dbg} !== 34'h0) begin errors++; $display("FAIL async_reset got %h exp 0", {a_end, a_valid, a_dbg}); end
        tick();
        i_reset_n = 1'b1;
        tick();
        checks++; if ({a_end, a_valid, a_ra} !== {2'b01, 32'h0}) begin errors++; $display("FAIL after_reset got %h exp 100000000", {a_end, a_valid, a_ra}); end
        idle();
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_load_use();
        test_branch();
        test_jump();
        test_load_imm();
        test_halt();
        test_program_end();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
